// File: rtl/message_assembler.sv
// ---------------------------------------------------------------------------
// message_assembler
//
// Receive-side message builder for the chat-bot UART link. Bytes arriving from
// the UART receiver are shifted in one per strobe; after MSG_BYTES of them the
// full word is handed to the consumer on a held output with a ready/ack
// handshake. If the consumer has not taken the previous message when a new
// one completes, the new one is dropped and the sticky overrun flag is set.
//
// Optional build macro: MSG_TIMEOUT_EN
//   When defined, a partial message that sees no byte for TIMEOUT_CYCLES
//   cycles is discarded and timeout_flag pulses for one cycle. When not
//   defined, partial messages wait indefinitely and timeout_flag is 0.
//
// Parameters
//   MSG_BYTES       bytes per message (2..16)
//   TIMEOUT_CYCLES  idle cycles before a partial message is discarded (>= 2)
//
// Ports
//   clk                     system clock, rising edge
//   reset                   synchronous, active-high reset
//   Byte_In                 received byte, valid with the strobe
//   byte_has_been_received  one strobe per byte (a held level = N bytes)
//   message_ack             consumer has taken Message_Out
//   Message_Out             last delivered message, first byte in the MSBs
//   message_ready           Message_Out holds an unconsumed message
//   overrun                 sticky: a completed message was dropped
//   byte_count              bytes collected for the message in progress
//   timeout_flag            one-cycle pulse when a partial message is dropped
// ---------------------------------------------------------------------------
module message_assembler #(
    parameter int MSG_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       Byte_In,
    input  logic                             byte_has_been_received,
    input  logic                             message_ack,
    output logic [8*MSG_BYTES-1:0]           Message_Out,
    output logic                             message_ready,
    output logic                             overrun,
    output logic [$clog2(MSG_BYTES+1)-1:0]   byte_count,
    output logic                             timeout_flag
);

    localparam int              CW       = $clog2(MSG_BYTES + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(MSG_BYTES - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [CW-1:0]               r_byteCount;
    logic [CW-1:0]               w_nextCount;
    logic [8*(MSG_BYTES-1)-1:0]  r_sreg;
    logic [8*MSG_BYTES-1:0]      w_candidate;
    logic [8*MSG_BYTES-1:0]      r_message;
    logic                        r_ready;
    logic                        r_overrun;
    logic                        r_timeoutFlag;
    logic                        w_complete;
    logic                        w_timeout;

    // Only the first MSG_BYTES-1 bytes need storage; the final byte is taken
    // straight from the input in the completing cycle.
    assign w_candidate = {r_sreg, Byte_In};
    assign w_complete  = byte_has_been_received && (r_byteCount == LAST_IDX);

`ifdef MSG_TIMEOUT_EN
    localparam int            IW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] r_idleCount;

    // A strobe in the limit cycle takes precedence, so the timeout is only
    // raised when no byte arrives.
    assign w_timeout = (r_state == COLLECT) && !byte_has_been_received &&
                       (r_idleCount == IDLE_LIMIT);

    // Counts consecutive byte-free cycles while a message is partially built.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idleCount <= '0;
        end else if (byte_has_been_received || (r_state == IDLE) || w_timeout) begin
            r_idleCount <= '0;
        end else begin
            r_idleCount <= r_idleCount + IW'(1);
        end
    end
`else
    logic w_unusedTimeoutCfg;

    assign w_timeout          = 1'b0;
    assign w_unusedTimeoutCfg = (TIMEOUT_CYCLES >= 2);
`endif

    // Next-state logic: every strobe advances the count; the completing
    // strobe wraps straight back to IDLE so collection never stalls.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_byteCount;
        if (byte_has_been_received) begin
            if (w_complete) begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end else begin
                w_nextState = COLLECT;
                w_nextCount = r_byteCount + CW'(1);
            end
        end else if (w_timeout) begin
            w_nextState = IDLE;
            w_nextCount = '0;
        end
    end

    // State and byte counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_byteCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_byteCount <= w_nextCount;
        end
    end

    // Shift register, delivery and handshake. A completion that coincides
    // with an ack replaces the held message instead of counting as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg        <= '0;
            r_message     <= '0;
            r_ready       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeoutFlag <= 1'b0;
        end else begin
            r_timeoutFlag <= w_timeout;
            if (byte_has_been_received) begin
                r_sreg <= w_candidate[8*(MSG_BYTES-1)-1:0];
            end else if (w_timeout) begin
                r_sreg <= '0;
            end

            if (w_complete) begin
                if (!r_ready || message_ack) begin
                    r_message <= w_candidate;
                    r_ready   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_ready && message_ack) begin
                r_ready <= 1'b0;
            end
        end
    end

    assign Message_Out   = r_message;
    assign message_ready = r_ready;
    assign overrun       = r_overrun;
    assign byte_count    = r_byteCount;
    assign timeout_flag  = r_timeoutFlag;

endmodule

// File: tb/tb_message_assembler.sv
// ---------------------------------------------------------------------------
// tb_message_assembler
//
// Self-checking bench for message_assembler (MSG_BYTES=8, TIMEOUT_CYCLES=20).
// A queue-based reference model tracks the bytes of the message in progress,
// the held message, ready, overrun and the timeout pulse; every cycle the DUT
// outputs are compared against it. Directed sequences add fixed expected
// constants on top of the model comparisons.
// ---------------------------------------------------------------------------
module tb_message_assembler;

    localparam int MSG = 8;
    localparam int TO  = 20;

    logic               clk;
    logic               reset;
    logic [7:0]         Byte_In;
    logic               byte_has_been_received;
    logic               message_ack;
    logic [8*MSG-1:0]   Message_Out;
    logic               message_ready;
    logic               overrun;
    logic [3:0]         byte_count;
    logic               timeout_flag;

    int checkCount = 0;
    int failCount  = 0;
    int tfPulses   = 0;

    // Reference model state
    logic [7:0]         mQ[$];
    logic [8*MSG-1:0]   mOut;
    bit                 mReady;
    bit                 mOverrun;
    bit                 mTimeout;
    int                 mGap;

    message_assembler #(
        .MSG_BYTES      (MSG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .Byte_In                (Byte_In),
        .byte_has_been_received (byte_has_been_received),
        .message_ack            (message_ack),
        .Message_Out            (Message_Out),
        .message_ready          (message_ready),
        .overrun                (overrun),
        .byte_count             (byte_count),
        .timeout_flag           (timeout_flag)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: advances one clock with the inputs of that cycle
    task automatic modelStep(input bit rst, input bit stb, input logic [7:0] b, input bit ack);
        bit               complete;
        logic [8*MSG-1:0] cand;
        complete = 1'b0;
        cand     = '0;
        mTimeout = 1'b0;
        if (rst) begin
            mQ.delete();
            mOut     = '0;
            mReady   = 1'b0;
            mOverrun = 1'b0;
            mGap     = 0;
            return;
        end
        if (stb) begin
            mQ.push_back(b);
            mGap = 0;
            if (mQ.size() == MSG) begin
                foreach (mQ[i]) cand = (cand << 8) | {56'd0, mQ[i]};
                mQ.delete();
                complete = 1'b1;
            end
        end else if (mQ.size() != 0) begin
            mGap++;
`ifdef MSG_TIMEOUT_EN
            if (mGap == TO) begin
                mQ.delete();
                mGap     = 0;
                mTimeout = 1'b1;
            end
`endif
        end else begin
            mGap = 0;
        end
        if (complete) begin
            if (!mReady || ack) begin
                mOut   = cand;
                mReady = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (mReady && ack) begin
            mReady = 1'b0;
        end
    endtask

    // Drives one cycle of inputs, steps the model and compares all outputs
    task automatic applyStimulus(input bit rst, input bit stb, input logic [7:0] b, input bit ack);
        reset                  = rst;
        byte_has_been_received = stb;
        Byte_In                = b;
        message_ack            = ack;
        @(posedge clk);
        modelStep(rst, stb, b, ack);
        #1;
        if (timeout_flag) tfPulses++;
        checkOutput("msg_out",   Message_Out,   mOut);
        checkOutput("ready",     message_ready, mReady);
        checkOutput("overrun",   overrun,       mOverrun);
        checkOutput("byte_cnt",  byte_count,    mQ.size());
        checkOutput("tmo_flag",  timeout_flag,  mTimeout);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 8'h00, 0);
    endtask

    logic [7:0] helloBytes[8] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h0A, 8'h00};

    initial begin
        int pct;
        reset = 1'b1;
        byte_has_been_received = 1'b0;
        Byte_In = 8'h00;
        message_ack = 1'b0;
        mOut = '0;
        mReady = 1'b0;
        mOverrun = 1'b0;
        mTimeout = 1'b0;
        mGap = 0;

        // Reset state
        applyStimulus(1, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("rst_msg", Message_Out, 64'h0);
        checkOutput("rst_cnt", byte_count, 4'd0);

        // Spaced "HELLO!\n\0" message
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, helloBytes[i], 0);
            checkOutput("hello_cnt", byte_count, (i + 1) % 8);
            if (i < 7) idleCycles(9);
        end
        checkOutput("hello_msg", Message_Out, 64'h48454C4C4F210A00);
        checkOutput("hello_rdy", message_ready, 1'b1);
        checkOutput("hello_ovr", overrun, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("ack_rdy", message_ready, 1'b0);
        checkOutput("ack_hold", Message_Out, 64'h48454C4C4F210A00);

        // Two back-to-back messages, never acknowledged
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'((i / 8) * 16 + (i % 8) + 1), 0);
        checkOutput("ovr_msg", Message_Out, 64'h0102030405060708);
        checkOutput("ovr_flag", overrun, 1'b1);

        // Same two messages with ack coinciding with the final strobe
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'((i / 8) * 16 + (i % 8) + 1), i == 15);
        checkOutput("ackc_msg", Message_Out, 64'h1112131415161718);
        checkOutput("ackc_rdy", message_ready, 1'b1);
        checkOutput("ackc_ovr", overrun, 1'b0);

        // Reset mid-message discards the partial bytes
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hEE, 0);
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 8'(8'hA0 + i), 0);
            if (i == 6) checkOutput("cont_rdy7", message_ready, 1'b0);
        end
        checkOutput("rst_mid_msg", Message_Out, 64'hA0A1A2A3A4A5A6A7);
        checkOutput("cont_rdy8", message_ready, 1'b1);

        // Long gap after a partial message
        applyStimulus(1, 0, 8'h00, 0);
        tfPulses = 0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h55, 0);
        idleCycles(25);
`ifdef MSG_TIMEOUT_EN
        checkOutput("tmo_pulses", tfPulses, 1);
        checkOutput("tmo_cnt", byte_count, 4'd0);
`else
        checkOutput("tmo_pulses", tfPulses, 0);
        checkOutput("tmo_cnt", byte_count, 4'd4);
        applyStimulus(1, 0, 8'h00, 0);
`endif
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'(8'h10 + i), 0);
        checkOutput("tmo_msg", Message_Out, 64'h1011121314151617);

        // Strobe arriving exactly when the idle counter sits at its limit
        applyStimulus(1, 0, 8'h00, 0);
        tfPulses = 0;
        applyStimulus(0, 1, 8'h33, 0);
        idleCycles(TO - 1);
        applyStimulus(0, 1, 8'h34, 0);
        checkOutput("edge_pulses", tfPulses, 0);
        checkOutput("edge_cnt", byte_count, 4'd2);

        // Randomized traffic with varying strobe density
        applyStimulus(1, 0, 8'h00, 0);
        for (int seg = 0; seg < 16; seg++) begin
            case (seg % 4)
                0:       pct = 5;
                1:       pct = 30;
                2:       pct = 70;
                default: pct = 100;
            endcase
            for (int c = 0; c < 150; c++) begin
                applyStimulus($urandom_range(0, 299) == 0,
                              $urandom_range(0, 99) < pct,
                              8'($urandom),
                              $urandom_range(0, 7) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
